// File: rtl/cv32e40x_pkg.sv
// Shared types and helpers for the set-bit enumerator.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package cv32e40x_pkg;

  // Scanner control states
  typedef enum logic [0:0] {
    BITSCAN_IDLE = 1'b0,
    BITSCAN_SCAN = 1'b1
  } bitscan_state_e;

  // Widest vector bitrev can handle; callers zero-extend to this width
  localparam int BITSCAN_MAX_LEN = 128;

  // Reverse the lowest len bits of vec; bits at or above len come back as 0
  function automatic logic [BITSCAN_MAX_LEN-1:0] bitrev(input logic [BITSCAN_MAX_LEN-1:0] vec,
                                                        input int len);
    logic [BITSCAN_MAX_LEN-1:0] res;
    res = '0;
    for (int i = 0; i < BITSCAN_MAX_LEN; i++) begin
      if (i < len) begin
        res[i] = vec[len-1-i];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cv32e40x_ff_one.sv
// Combinational find-first-one: index of the lowest set bit of in_i.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no_ones_o flags an all-zero input (first_one_o is then 0).
module cv32e40x_ff_one #(
  parameter  int LEN   = 32,
  localparam int IDX_W = $clog2(LEN)
) (
  input  logic [LEN-1:0]   in_i,
  output logic [IDX_W-1:0] first_one_o,
  output logic             no_ones_o
);

  // Walk from the top down so the lowest set bit is the last one written
  always_comb begin
    first_one_o = '0;
    no_ones_o   = 1'b1;
    for (int i = LEN - 1; i >= 0; i--) begin
      if (in_i[i]) begin
        first_one_o = IDX_W'(i);
        no_ones_o   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cv32e40x_bitscan_iter.sv
// Streams the index of every set bit of an accepted vector, LSB- or MSB-first, one beat per cycle.
// Latency: vector accepted in cycle N gives first beat in N+1; back-to-back reload on the last beat.
// Backpressure: out_ready_i=0 freezes the beat; in_ready_o only while idle or during the last handshake.
// Optional: define CV32E40X_BITSCAN_COUNT_EN to add out_remaining_o (beats left including current).
module cv32e40x_bitscan_iter
  import cv32e40x_pkg::*;
#(
  parameter  int LEN       = 32,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int IDX_W     = $clog2(LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [LEN-1:0]   in_vec_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IDX_W-1:0] out_index_o,
  output logic             out_last_o,
  output logic             out_none_o
`ifdef CV32E40X_BITSCAN_COUNT_EN
  ,
  output logic [$clog2(LEN+1)-1:0] out_remaining_o
`endif
);

  bitscan_state_e   state_q, state_d;
  logic [LEN-1:0]   rem_q, rem_d;
  logic [LEN-1:0]   scan_vec;
  logic [LEN-1:0]   clr_mask;
  logic [IDX_W-1:0] found_idx;
  logic             no_ones;
  logic             single_one;
  logic             in_hs;
  logic             out_hs;

  // MSB-first order searches the mirrored vector so one lowest-bit finder serves both orders
  assign scan_vec = MSB_FIRST ? LEN'(bitrev(BITSCAN_MAX_LEN'(rem_q), LEN)) : rem_q;

  cv32e40x_ff_one #(
    .LEN (LEN)
  ) u_ff_one (
    .in_i        (scan_vec),
    .first_one_o (found_idx),
    .no_ones_o   (no_ones)
  );

  assign single_one = ((rem_q & (rem_q - LEN'(1))) == '0) && !no_ones;
  assign in_hs      = in_valid_i & in_ready_o;
  assign out_hs     = out_valid_o & out_ready_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BITSCAN_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Remaining-bits register: holds the set bits not yet emitted
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  // Next state and next remaining vector; kill overrides every handshake
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    clr_mask = '0;
    clr_mask[out_index_o] = 1'b1;
    if (kill_i) begin
      state_d = BITSCAN_IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        BITSCAN_IDLE: begin
          if (in_hs) begin
            state_d = BITSCAN_SCAN;
            rem_d   = in_vec_i;
          end
        end
        BITSCAN_SCAN: begin
          if (out_hs) begin
            if (out_last_o) begin
              if (in_hs) begin
                rem_d = in_vec_i;
              end else begin
                state_d = BITSCAN_IDLE;
                rem_d   = '0;
              end
            end else begin
              rem_d = rem_q & ~clr_mask;
            end
          end
        end
        default: begin
          state_d = BITSCAN_IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  // Outputs decoded from state and rem_q; idle outputs sit at zero
  always_comb begin
    out_valid_o = (state_q == BITSCAN_SCAN);
    out_index_o = '0;
    out_last_o  = 1'b0;
    out_none_o  = 1'b0;
    if (out_valid_o) begin
      if (!no_ones) begin
        out_index_o = MSB_FIRST ? (IDX_W'(LEN - 1) - found_idx) : found_idx;
      end
      out_last_o = no_ones | single_one;
      out_none_o = no_ones;
    end
    in_ready_o = !kill_i && (!out_valid_o || (out_ready_i && out_last_o));
  end

`ifdef CV32E40X_BITSCAN_COUNT_EN
  localparam int CNT_W = $clog2(LEN + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d, in_pop;

  // Population count of the incoming vector, loaded together with rem_q
  always_comb begin
    in_pop = '0;
    for (int i = 0; i < LEN; i++) begin
      in_pop = in_pop + CNT_W'(in_vec_i[i]);
    end
  end

  // Counter follows rem_q: load on accept, step down per beat, clear on last/kill
  always_comb begin
    cnt_d = cnt_q;
    if (kill_i) begin
      cnt_d = '0;
    end else if (in_hs) begin
      cnt_d = in_pop;
    end else if (out_hs) begin
      cnt_d = out_last_o ? '0 : (cnt_q - CNT_W'(1));
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_remaining_o = cnt_q;
`endif

  a_idx_range : assert property (@(posedge clk) disable iff (rst)
    out_valid_o |-> (32'(out_index_o) < LEN));

  a_none_last : assert property (@(posedge clk) disable iff (rst)
    out_none_o |-> out_last_o);

  a_stall_stable : assert property (@(posedge clk) disable iff (rst)
    (out_valid_o && !out_ready_i && !kill_i) |=>
      (out_valid_o && $stable(out_index_o) && $stable(out_last_o) && $stable(out_none_o)));

endmodule

// File: tb/tb_cv32e40x_bitscan_iter.sv
// Bench for the set-bit enumerator: three instances (32 LSB-first, 32 MSB-first, 5 LSB-first)
// share one stimulus stream; a list-based model predicts every beat, plus literal spot checks.
module tb_cv32e40x_bitscan_iter;

  logic        clk = 1'b0;
  logic        rst, kill, in_valid, out_ready;
  logic [31:0] in_vec;

  logic [2:0]  o_rdy, o_vld, o_last, o_none;
  logic [4:0]  idx0, idx1;
  logic [2:0]  idx2;
`ifdef CV32E40X_BITSCAN_COUNT_EN
  logic [5:0]  rem0, rem1;
  logic [2:0]  rem2;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: per instance, ordered list of indices still to be emitted
  bit [2:0] mbusy = '0;
  int       mlist [3][32];
  int       mhead [3] = '{default: 0};
  int       mcnt  [3] = '{default: 0};

  always #5 clk = ~clk;

  cv32e40x_bitscan_iter #(.LEN(32), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .kill_i(kill), .in_valid_i(in_valid), .in_ready_o(o_rdy[0]),
    .in_vec_i(in_vec), .out_valid_o(o_vld[0]), .out_ready_i(out_ready), .out_index_o(idx0),
    .out_last_o(o_last[0]), .out_none_o(o_none[0])
`ifdef CV32E40X_BITSCAN_COUNT_EN
    , .out_remaining_o(rem0)
`endif
  );

  cv32e40x_bitscan_iter #(.LEN(32), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .kill_i(kill), .in_valid_i(in_valid), .in_ready_o(o_rdy[1]),
    .in_vec_i(in_vec), .out_valid_o(o_vld[1]), .out_ready_i(out_ready), .out_index_o(idx1),
    .out_last_o(o_last[1]), .out_none_o(o_none[1])
`ifdef CV32E40X_BITSCAN_COUNT_EN
    , .out_remaining_o(rem1)
`endif
  );

  cv32e40x_bitscan_iter #(.LEN(5), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst(rst), .kill_i(kill), .in_valid_i(in_valid), .in_ready_o(o_rdy[2]),
    .in_vec_i(in_vec[4:0]), .out_valid_o(o_vld[2]), .out_ready_i(out_ready), .out_index_o(idx2),
    .out_last_o(o_last[2]), .out_none_o(o_none[2])
`ifdef CV32E40X_BITSCAN_COUNT_EN
    , .out_remaining_o(rem2)
`endif
  );

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] act_idx(int k);
    case (k)
      0:       return 32'(idx0);
      1:       return 32'(idx1);
      default: return 32'(idx2);
    endcase
  endfunction

`ifdef CV32E40X_BITSCAN_COUNT_EN
  function automatic logic [31:0] act_rem(int k);
    case (k)
      0:       return 32'(rem0);
      1:       return 32'(rem1);
      default: return 32'(rem2);
    endcase
  endfunction
`endif

  function automatic bit exp_last(int k);
    return (mcnt[k] - mhead[k]) <= 1;
  endfunction

  function automatic bit exp_none(int k);
    return mcnt[k] == 0;
  endfunction

  function automatic int exp_idx(int k);
    if (mhead[k] >= mcnt[k]) return 0;
    return mlist[k][mhead[k]];
  endfunction

  function automatic bit exp_rdy(int k);
    return !kill && (!mbusy[k] || (out_ready && exp_last(k)));
  endfunction

  // Model update on each rising edge from the inputs held through the cycle
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit r;
      int n;
      int len;
      int b;
      r   = exp_rdy(k);
      len = (k == 2) ? 5 : 32;
      n   = 0;
      if (rst || kill) begin
        mbusy[k] <= 1'b0;
      end else begin
        if (mbusy[k] && out_ready) begin
          if (exp_last(k)) mbusy[k] <= 1'b0;
          else             mhead[k] <= mhead[k] + 1;
        end
        if (in_valid && r) begin
          for (int j = 0; j < len; j++) begin
            b = (k == 1) ? (len - 1 - j) : j;
            if (in_vec[b]) begin
              mlist[k][n] <= b;
              n++;
            end
          end
          mcnt[k]  <= n;
          mhead[k] <= 0;
          mbusy[k] <= 1'b1;
        end
      end
    end
  end

  // Compare all outputs against the model every cycle, just after inputs settle
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk("in_ready", k, 32'(o_rdy[k]), 32'(exp_rdy(k)));
        chk("out_valid", k, 32'(o_vld[k]), 32'(mbusy[k]));
        if (mbusy[k]) begin
          chk("out_index", k, act_idx(k), exp_idx(k));
          chk("out_last", k, 32'(o_last[k]), 32'(exp_last(k)));
          chk("out_none", k, 32'(o_none[k]), 32'(exp_none(k)));
`ifdef CV32E40X_BITSCAN_COUNT_EN
          chk("out_remaining", k, act_rem(k), mcnt[k] - mhead[k]);
`endif
        end
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] vec, input logic r,
                      input logic k, input logic rs);
    @(negedge clk);
    in_valid  = v;
    in_vec    = vec;
    out_ready = r;
    kill      = k;
    rst       = rs;
    #2;
  endtask

  task automatic chk_idle(input string nm);
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_vld"}, k, 32'(o_vld[k]), 0);
      chk({nm, "_rdy"}, k, 32'(o_rdy[k]), 1);
      chk({nm, "_idx"}, k, act_idx(k), 0);
      chk({nm, "_last"}, k, 32'(o_last[k]), 0);
      chk({nm, "_none"}, k, 32'(o_none[k]), 0);
    end
  endtask

  initial begin
    logic [31:0] rv;
    in_valid = 1'b0; in_vec = '0; out_ready = 1'b1; kill = 1'b0; rst = 1'b1;
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    chk_en = 1'b1;

    // Reset state, then 0x8000_0011 in both orders with a back-to-back 0x1
    step(1, 32'h8000_0011, 1, 0, 0);
    chk_idle("reset");
    step(0, 0, 1, 0, 0);
    chk("t1_idx", 0, act_idx(0), 0);
    chk("t1_last", 0, 32'(o_last[0]), 0);
    chk("t1_idx", 1, act_idx(1), 31);
    chk("t1_idx", 2, act_idx(2), 0);
`ifdef CV32E40X_BITSCAN_COUNT_EN
    chk("t1_rem", 0, act_rem(0), 3);
    chk("t1_rem", 2, act_rem(2), 2);
`endif
    step(0, 0, 1, 0, 0);
    chk("t1_idx", 0, act_idx(0), 4);
    chk("t1_idx", 1, act_idx(1), 4);
    chk("t1_idx", 2, act_idx(2), 4);
    chk("t1_last", 2, 32'(o_last[2]), 1);
`ifdef CV32E40X_BITSCAN_COUNT_EN
    chk("t1_rem", 2, act_rem(2), 1);
`endif
    step(1, 32'h1, 1, 0, 0);
    chk("t1_idx", 0, act_idx(0), 31);
    chk("t1_last", 0, 32'(o_last[0]), 1);
    chk("t1_idx", 1, act_idx(1), 0);
    chk("t1_rdy", 1, 32'(o_rdy[1]), 1);
    step(0, 0, 1, 0, 0);
    chk("b2b_vld", 1, 32'(o_vld[1]), 1);
    chk("b2b_idx", 1, act_idx(1), 0);
    chk("b2b_last", 1, 32'(o_last[1]), 1);
    step(0, 0, 1, 0, 0);
    chk("t1_end_vld", 0, 32'(o_vld[0]), 0);

    // All-zero vector
    step(1, 32'h0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("zero_vld", 0, 32'(o_vld[0]), 1);
    chk("zero_none", 0, 32'(o_none[0]), 1);
    chk("zero_last", 0, 32'(o_last[0]), 1);
    chk("zero_idx", 0, act_idx(0), 0);
    step(0, 0, 1, 0, 0);
    chk("zero_end_vld", 0, 32'(o_vld[0]), 0);

    // Stall with 0xF: first beat held three cycles, then 1,2,3
    step(1, 32'hF, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("stall_idx", 0, act_idx(0), 0);
      chk("stall_idx", 1, act_idx(1), 3);
    end
    step(0, 0, 1, 0, 0);
    chk("stall_rel", 0, act_idx(0), 0);
    for (int i = 1; i < 4; i++) begin
      step(0, 0, 1, 0, 0);
      chk("stall_seq", 0, act_idx(0), i);
    end
    chk("stall_last", 0, 32'(o_last[0]), 1);

    // Kill on the second beat of 0x00FF, then 0x2 yields beat 1 only
    step(1, 32'h00FF, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("kill_b0", 0, act_idx(0), 0);
    step(0, 0, 1, 1, 0);
    chk("kill_b1", 0, act_idx(0), 1);
    chk("kill_rdy", 0, 32'(o_rdy[0]), 0);
    step(1, 32'h2, 1, 0, 0);
    chk("kill_vld", 0, 32'(o_vld[0]), 0);
    chk("kill_rdy_after", 0, 32'(o_rdy[0]), 1);
    step(0, 0, 1, 0, 0);
    chk("kill_new_idx", 0, act_idx(0), 1);
    chk("kill_new_last", 0, 32'(o_last[0]), 1);
    step(0, 0, 1, 0, 0);
    chk("kill_end_vld", 0, 32'(o_vld[0]), 0);

    // Reset in the middle of a scan
    step(1, 32'h8000_0011, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    chk_idle("midrst");

    // Randomised traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0:       rv = 32'h0;
        1:       rv = 32'h1 << $urandom_range(0, 31);
        2:       rv = $urandom;
        default: rv = $urandom & $urandom & $urandom;
      endcase
      step(1'($urandom_range(0, 1)), rv, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
